// File: rtl/alu_multicycle_if.sv
// Handshake bundle between operand issue and result writeback for alu_multicycle.
// master drives operations and accepts results; slave is the ALU.
interface alu_multicycle_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       aluCmd;
  logic [WIDTH-1:0] lhs;
  logic [WIDTH-1:0] rhs;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;
  logic             illegal;

  modport master (
    output in_valid, aluCmd, lhs, rhs, out_ready,
    input  in_ready, out_valid, result, div_by_zero, illegal
  );

  modport slave (
    input  in_valid, aluCmd, lhs, rhs, out_ready,
    output in_ready, out_valid, result, div_by_zero, illegal
  );
endinterface

// File: rtl/alu_multicycle.sv
// Handshaked ALU: single-cycle logic/arith ops plus iterative shift-add multiply and
// restoring divide, each taking WIDTH iterations between accept and result.
module alu_multicycle #(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input logic             clk,
  input logic             reset,
  alu_multicycle_if.slave bus
);

  localparam logic [3:0] CmdNop  = 4'd0;
  localparam logic [3:0] CmdAdd  = 4'd1;
  localparam logic [3:0] CmdSub  = 4'd2;
  localparam logic [3:0] CmdAnd  = 4'd3;
  localparam logic [3:0] CmdOr   = 4'd4;
  localparam logic [3:0] CmdXor  = 4'd5;
  localparam logic [3:0] CmdSlt  = 4'd6;
  localparam logic [3:0] CmdSltu = 4'd7;
  localparam logic [3:0] CmdSll  = 4'd8;
  localparam logic [3:0] CmdSrl  = 4'd9;
  localparam logic [3:0] CmdSra  = 4'd10;
  localparam logic [3:0] CmdMul  = 4'd11;
  localparam logic [3:0] CmdDivu = 4'd12;
  localparam logic [3:0] CmdRemu = 4'd13;

  localparam logic [SHW:0] CntInit = WIDTH[SHW:0];
  localparam logic [SHW:0] CntOne  = {{SHW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             dbz_q, dbz_d;
  logic             ill_q, ill_d;

  logic             accept;
  logic             is_multi;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] single_res;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;

  assign bus.in_ready    = (state_q == StIdle) || ((state_q == StDone) && bus.out_ready);
  assign bus.out_valid   = (state_q == StDone);
  assign bus.result      = result_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.illegal     = ill_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign is_multi = (bus.aluCmd == CmdMul) || (bus.aluCmd == CmdDivu) ||
                    (bus.aluCmd == CmdRemu);
  assign sh       = bus.rhs[SHW-1:0];

  always_comb begin
    single_res = '0;
    case (bus.aluCmd)
      CmdAdd:  single_res = bus.lhs + bus.rhs;
      CmdSub:  single_res = bus.lhs - bus.rhs;
      CmdAnd:  single_res = bus.lhs & bus.rhs;
      CmdOr:   single_res = bus.lhs | bus.rhs;
      CmdXor:  single_res = bus.lhs ^ bus.rhs;
      CmdSlt:  single_res = {{(WIDTH-1){1'b0}}, $signed(bus.lhs) < $signed(bus.rhs)};
      CmdSltu: single_res = {{(WIDTH-1){1'b0}}, bus.lhs < bus.rhs};
      CmdSll:  single_res = bus.lhs << sh;
      CmdSrl:  single_res = bus.lhs >> sh;
      CmdSra:  single_res = $unsigned($signed(bus.lhs) >>> sh);
      default: single_res = '0;
    endcase
  end

  // Iteration datapath. MUL: op_a = shifted multiplicand, op_b = multiplier, acc = product.
  // DIV: op_a = dividend shifting out / quotient shifting in, op_b = divisor, acc = remainder.
  // A zero divisor naturally yields all-ones quotient and remainder == dividend.
  always_comb begin
    mul_acc   = op_b_q[0] ? (acc_q + op_a_q) : acc_q;
    rem_shift = {acc_q, op_a_q[WIDTH-1]};
    if (rem_shift >= {1'b0, op_b_q}) begin
      div_rem = rem_shift[WIDTH-1:0] - op_b_q;
      div_quo = {op_a_q[WIDTH-2:0], 1'b1};
    end else begin
      div_rem = rem_shift[WIDTH-1:0];
      div_quo = {op_a_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    ill_d    = ill_q;
    case (state_q)
      StIdle, StDone: begin
        if ((state_q == StDone) && bus.out_ready) state_d = StIdle;
        if (accept) begin
          cmd_d  = bus.aluCmd;
          op_a_d = bus.lhs;
          op_b_d = bus.rhs;
          dbz_d  = 1'b0;
          ill_d  = 1'b0;
          if (is_multi) begin
            state_d = StBusy;
            cnt_d   = CntInit;
            acc_d   = '0;
            dbz_d   = (bus.aluCmd != CmdMul) && (bus.rhs == '0);
          end else begin
            state_d  = StDone;
            result_d = single_res;
            ill_d    = (bus.aluCmd > CmdRemu);
          end
        end
      end
      StBusy: begin
        if (cmd_q == CmdMul) begin
          acc_d  = mul_acc;
          op_a_d = op_a_q << 1;
          op_b_d = op_b_q >> 1;
        end else begin
          acc_d  = div_rem;
          op_a_d = div_quo;
        end
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          state_d = StDone;
          if (cmd_q == CmdMul)       result_d = mul_acc;
          else if (cmd_q == CmdDivu) result_d = div_quo;
          else                       result_d = div_rem;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cmd_q    <= CmdNop;
      op_a_q   <= '0;
      op_b_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
      ill_q    <= ill_d;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed-vector bench for alu_multicycle: latency, handshake, stall, reset and op results
// against hand-computed values.
module tb_alu_multicycle;

  localparam logic [3:0] CmdNop  = 4'd0;
  localparam logic [3:0] CmdAdd  = 4'd1;
  localparam logic [3:0] CmdSub  = 4'd2;
  localparam logic [3:0] CmdAnd  = 4'd3;
  localparam logic [3:0] CmdOr   = 4'd4;
  localparam logic [3:0] CmdXor  = 4'd5;
  localparam logic [3:0] CmdSlt  = 4'd6;
  localparam logic [3:0] CmdSltu = 4'd7;
  localparam logic [3:0] CmdSll  = 4'd8;
  localparam logic [3:0] CmdSrl  = 4'd9;
  localparam logic [3:0] CmdSra  = 4'd10;
  localparam logic [3:0] CmdMul  = 4'd11;
  localparam logic [3:0] CmdDivu = 4'd12;
  localparam logic [3:0] CmdRemu = 4'd13;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  alu_multicycle_if #(.WIDTH(32)) bus ();

  alu_multicycle #(.WIDTH(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; issues one op and waits for its result.
  task automatic run_op(input string tag, input logic [3:0] cmd, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic exp_dbz,
                        input logic exp_ill, input int exp_lat, input bit poke);
    int lat;
    int busy_rdy;
    check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.aluCmd    = cmd;
    bus.lhs       = a;
    bus.rhs       = b;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.lhs      = ~a;
    bus.rhs      = ~b;
    lat      = 1;
    busy_rdy = 0;
    while (!bus.out_valid && lat < 80) begin
      if (bus.in_ready) busy_rdy++;
      if (poke && lat == 5) begin
        bus.in_valid = 1'b1;
        bus.aluCmd   = CmdAdd;
      end
      if (poke && lat == 7) bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_result"}, bus.result, exp_res);
    check_eq({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(exp_dbz));
    check_eq({tag, "_illegal"}, 32'(bus.illegal), 32'(exp_ill));
    if (exp_lat > 1) check_eq({tag, "_busy_ready"}, 32'(busy_rdy), 32'd0);
  endtask

  initial begin
    int quiet_err;
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.aluCmd    = CmdNop;
    bus.lhs       = '0;
    bus.rhs       = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_result", bus.result, 32'd0);
    check_eq("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    check_eq("rst_illegal", 32'(bus.illegal), 32'd0);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back single-cycle ops
    run_op("add_wrap", CmdAdd, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 0, 0, 1, 0);
    run_op("sub_neg", CmdSub, 32'd5, 32'd7, 32'hFFFF_FFFE, 0, 0, 1, 0);
    run_op("sra", CmdSra, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 0, 0, 1, 0);
    run_op("slt", CmdSlt, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0, 1, 0);
    run_op("sltu", CmdSltu, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0, 1, 0);
    run_op("and", CmdAnd, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, 0, 0, 1, 0);
    run_op("or", CmdOr, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'hFFF0_FFF0, 0, 0, 1, 0);
    run_op("xor", CmdXor, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'hFF00_0FF0, 0, 0, 1, 0);
    run_op("sll", CmdSll, 32'd1, 32'h0000_003F, 32'h8000_0000, 0, 0, 1, 0);
    run_op("srl", CmdSrl, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 0, 0, 1, 0);
    run_op("nop", CmdNop, 32'd5, 32'd6, 32'd0, 0, 0, 1, 0);
    run_op("ill15", 4'd15, 32'd5, 32'd6, 32'd0, 0, 1, 1, 0);

    // Multi-cycle ops; the MUL also sees an in_valid pulse while busy
    run_op("mul", CmdMul, 32'h0001_0003, 32'h0000_0100, 32'h0100_0300, 0, 0, 33, 1);
    @(posedge clk);
    #1;
    check_eq("mul_no_extra", 32'(bus.out_valid), 32'd0);
    run_op("mul_wrap", CmdMul, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 0, 0, 33, 0);
    run_op("divu", CmdDivu, 32'd100, 32'd7, 32'd14, 0, 0, 33, 0);
    run_op("remu", CmdRemu, 32'd100, 32'd7, 32'd2, 0, 0, 33, 0);
    run_op("divu_big", CmdDivu, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 0, 0, 33, 0);
    run_op("remu_big", CmdRemu, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 0, 0, 33, 0);
    run_op("divu_zero", CmdDivu, 32'd9, 32'd0, 32'hFFFF_FFFF, 1, 0, 33, 0);
    run_op("remu_zero", CmdRemu, 32'd9, 32'd0, 32'd9, 1, 0, 33, 0);
    run_op("add_clr", CmdAdd, 32'd3, 32'd4, 32'd7, 0, 0, 1, 0);

    // Consumer stall with an illegal op waiting, then accept on the releasing edge
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b1;
    bus.aluCmd    = CmdAdd;
    bus.lhs       = 32'd10;
    bus.rhs       = 32'd20;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.aluCmd = 4'd14;
    bus.lhs    = 32'd1;
    bus.rhs    = 32'd2;
    for (int i = 0; i < 5; i++) begin
      check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
      check_eq("hold_result", bus.result, 32'd30);
      check_eq("hold_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check_eq("ill14_valid", 32'(bus.out_valid), 32'd1);
    check_eq("ill14_result", bus.result, 32'd0);
    check_eq("ill14_illegal", 32'(bus.illegal), 32'd1);
    @(posedge clk);
    #1;
    check_eq("idle_after", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of a divide
    bus.in_valid = 1'b1;
    bus.aluCmd   = CmdDivu;
    bus.lhs      = 32'd1000;
    bus.rhs      = 32'd3;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_eq("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_mid_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_mid_result", bus.result, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    quiet_err = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) quiet_err++;
    end
    check_eq("rst_no_stale", 32'(quiet_err), 32'd0);
    run_op("add_post", CmdAdd, 32'd1, 32'd1, 32'd2, 0, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
